// File: rtl/mux_sel_switch.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_switch
// Description : Registered N-to-1 lane selector with select handshake and a
//               blanking window on select changes. Optional range check via
//               MUX_SEL_CHECK_EN (adds sticky sel_err output).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_switch #(
    parameter int NUM_INPUTS    = 8,
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2,
    localparam int SEL_W        = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        sel_req,
    output logic                        sel_ack,
    output logic                        sel_drop,
    output logic                        busy,
    output logic [SEL_W-1:0]            cur_sel,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic                        sel_err
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_cur_sel;
    logic [SEL_W-1:0]   r_pend_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_sel_ack;
    logic               r_sel_drop;
    logic               r_drop_defer;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_cur_sel_nxt;
    logic [SEL_W-1:0]   w_pend_sel_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_out_data_nxt;
    logic               w_out_valid_nxt;
    logic               w_ack_nxt;
    logic               w_drop_raw;
    logic               w_drop_nxt;
    logic               w_drop_defer_nxt;

    logic [WIDTH-1:0]   w_lane_data;
    logic               w_lane_valid;

`ifdef MUX_SEL_CHECK_EN
    localparam logic [SEL_W:0] c_num_inputs = (SEL_W + 1)'(NUM_INPUTS);
    logic               r_sel_err;
    logic               w_sel_err_nxt;
    logic               w_sel_oor;

    assign w_sel_oor = ({1'b0, sel} >= c_num_inputs);
`endif

    // An out-of-range cur_sel matches no lane and therefore yields zero data/valid.
    always_comb begin
        w_lane_data  = '0;
        w_lane_valid = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_cur_sel == SEL_W'(i)) begin
                w_lane_data  = in_data[i*WIDTH +: WIDTH];
                w_lane_valid = in_valid[i];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_sel_nxt   = r_cur_sel;
        w_pend_sel_nxt  = r_pend_sel;
        w_cnt_nxt       = r_cnt;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = 1'b0;
        w_ack_nxt       = 1'b0;
        w_drop_raw      = 1'b0;
`ifdef MUX_SEL_CHECK_EN
        w_sel_err_nxt   = r_sel_err | (sel_req & w_sel_oor);
`endif

        case (r_state)
            ST_RUN: begin
                w_out_data_nxt  = w_lane_data;
                w_out_valid_nxt = w_lane_valid;
                if (sel_req) begin
`ifdef MUX_SEL_CHECK_EN
                    if (w_sel_oor) begin
                        w_drop_raw = 1'b1;
                    end else
`endif
                    if (sel == r_cur_sel) begin
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_pend_sel_nxt  = sel;
                        w_cnt_nxt       = c_settle;
                        w_state_nxt     = ST_BLANK;
                        w_out_valid_nxt = 1'b0;
                        w_out_data_nxt  = r_out_data;
                    end
                end
            end

            ST_BLANK: begin
                if (sel_req) begin
                    w_drop_raw = 1'b1;
                end
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_cur_sel_nxt = r_pend_sel;
                    w_ack_nxt     = 1'b1;
                    w_state_nxt   = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // A drop that lands on an ack cycle is held back one cycle so the two
        // pulses never overlap and no rejected request goes unreported.
        w_drop_nxt       = ~w_ack_nxt & (w_drop_raw | r_drop_defer);
        w_drop_defer_nxt =  w_ack_nxt & (w_drop_raw | r_drop_defer);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_cur_sel    <= '0;
            r_pend_sel   <= '0;
            r_cnt        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_sel_ack    <= 1'b0;
            r_sel_drop   <= 1'b0;
            r_drop_defer <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_sel    <= w_cur_sel_nxt;
            r_pend_sel   <= w_pend_sel_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_sel_ack    <= w_ack_nxt;
            r_sel_drop   <= w_drop_nxt;
            r_drop_defer <= w_drop_defer_nxt;
        end
    end

`ifdef MUX_SEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_sel_err_nxt;
        end
    end

    assign sel_err = r_sel_err;
`endif

    assign sel_ack   = r_sel_ack;
    assign sel_drop  = r_sel_drop;
    assign busy      = (r_state == ST_BLANK);
    assign cur_sel   = r_cur_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sel_switch
// Description : Directed self-checking bench for mux_sel_switch (8-lane and
//               6-lane instances, SETTLE_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_switch;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [2:0]  sel;
    logic        sel_req;
    logic        sel_ack, sel_drop, busy, out_valid;
    logic [2:0]  cur_sel;
    logic [7:0]  out_data;

    logic [47:0] in_data6;
    logic [5:0]  in_valid6;
    logic [2:0]  sel6;
    logic        sel_req6;
    logic        sel_ack6, sel_drop6, busy6, out_valid6;
    logic [2:0]  cur_sel6;
    logic [7:0]  out_data6;
`ifdef MUX_SEL_CHECK_EN
    logic        sel_err;
    logic        sel_err6;
`endif

    int n_checks = 0;
    int n_errors = 0;

    assign in_data6  = in_data[47:0];
    assign in_valid6 = in_valid[5:0];

    always #5 clk = ~clk;

    mux_sel_switch #(.NUM_INPUTS(8), .WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .sel(sel), .sel_req(sel_req), .sel_ack(sel_ack), .sel_drop(sel_drop),
        .busy(busy), .cur_sel(cur_sel), .out_data(out_data), .out_valid(out_valid)
`ifdef MUX_SEL_CHECK_EN
        , .sel_err(sel_err)
`endif
    );

    mux_sel_switch #(.NUM_INPUTS(6), .WIDTH(8), .SETTLE_CYCLES(2)) dut6 (
        .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
        .sel(sel6), .sel_req(sel_req6), .sel_ack(sel_ack6), .sel_drop(sel_drop6),
        .busy(busy6), .cur_sel(cur_sel6), .out_data(out_data6), .out_valid(out_valid6)
`ifdef MUX_SEL_CHECK_EN
        , .sel_err(sel_err6)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel_req = 1'b0; sel_req6 = 1'b0; sel = '0; sel6 = '0;
        in_valid = 8'hFF;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
        in_data[3*8 +: 8] = 8'hA5;
        step(); step();
        n_checks++; if (cur_sel !== 3'd0) begin n_errors++; $display("FAIL reset_cur_sel: got %0d expected 0", cur_sel); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++; if ({busy, sel_ack, sel_drop} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {busy, sel_ack, sel_drop}); end
`ifdef MUX_SEL_CHECK_EN
        n_checks++; if (sel_err6 !== 1'b0) begin n_errors++; $display("FAIL reset_sel_err: got %b expected 0", sel_err6); end
`endif
        rst = 1'b0;
        step();
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h10}) begin n_errors++; $display("FAIL run_lane0: got %b/%h expected 1/10", out_valid, out_data); end
        n_checks++; if ({out_valid6, out_data6} !== {1'b1, 8'h10}) begin n_errors++; $display("FAIL run6_lane0: got %b/%h expected 1/10", out_valid6, out_data6); end
    endtask

    task automatic test_switch();
        sel = 3'd3; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        n_checks++; if ({busy, out_valid, sel_ack} !== 3'b100) begin n_errors++; $display("FAIL switch_k: busy/valid/ack got %b expected 100", {busy, out_valid, sel_ack}); end
        for (int j = 1; j <= 3; j++) begin
            step();
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL switch_blank_valid k+%0d: got %b expected 0", j, out_valid); end
            n_checks++; if (sel_ack !== (j == 3)) begin n_errors++; $display("FAIL switch_ack k+%0d: got %b expected %b", j, sel_ack, (j == 3)); end
            n_checks++; if (cur_sel !== ((j == 3) ? 3'd3 : 3'd0)) begin n_errors++; $display("FAIL switch_cur_sel k+%0d: got %0d", j, cur_sel); end
        end
        step();
        n_checks++; if ({out_valid, out_data, sel_ack, busy} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin n_errors++; $display("FAIL switch_data k+4: got %b/%h ack %b busy %b expected 1/a5 0 0", out_valid, out_data, sel_ack, busy); end
    endtask

    task automatic test_same_lane();
        sel = 3'd3; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        n_checks++; if ({sel_ack, busy, out_valid} !== 3'b101) begin n_errors++; $display("FAIL same_lane_ack: ack/busy/valid got %b expected 101", {sel_ack, busy, out_valid}); end
        step();
        n_checks++; if ({sel_ack, busy, out_valid, out_data} !== {3'b001, 8'hA5}) begin n_errors++; $display("FAIL same_lane_after: got %b/%h expected 001/a5", {sel_ack, busy, out_valid}, out_data); end
    endtask

    task automatic test_busy_drop();
        sel = 3'd5; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        step();
        sel = 3'd1; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        n_checks++; if ({sel_drop, sel_ack, busy} !== 3'b101) begin n_errors++; $display("FAIL busy_drop: drop/ack/busy got %b expected 101", {sel_drop, sel_ack, busy}); end
        step();
        n_checks++; if ({cur_sel, sel_ack, sel_drop} !== {3'd5, 2'b10}) begin n_errors++; $display("FAIL busy_apply: cur_sel %0d ack %b drop %b expected 5 1 0", cur_sel, sel_ack, sel_drop); end
        for (int j = 0; j < 3; j++) begin
            step();
            n_checks++; if ({cur_sel, busy, out_valid, out_data} !== {3'd5, 2'b01, 8'h15}) begin n_errors++; $display("FAIL busy_hold %0d: cur_sel %0d busy %b valid %b data %h expected 5 0 1 15", j, cur_sel, busy, out_valid, out_data); end
        end
    endtask

    task automatic test_back_to_back();
        sel = 3'd2; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        step(); step();
        sel = 3'd1; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        n_checks++; if ({sel_ack, sel_drop, busy, cur_sel} !== {3'b100, 3'd2}) begin n_errors++; $display("FAIL b2b_switch_edge: ack %b drop %b busy %b cur_sel %0d expected 1 0 0 2", sel_ack, sel_drop, busy, cur_sel); end
        step();
        n_checks++; if ({sel_ack, sel_drop, busy, cur_sel} !== {3'b010, 3'd2}) begin n_errors++; $display("FAIL b2b_deferred_drop: ack %b drop %b busy %b cur_sel %0d expected 0 1 0 2", sel_ack, sel_drop, busy, cur_sel); end
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h12}) begin n_errors++; $display("FAIL b2b_data: got %b/%h expected 1/12", out_valid, out_data); end
        step();
        n_checks++; if ({sel_drop, busy} !== 2'b00) begin n_errors++; $display("FAIL b2b_quiet: drop %b busy %b expected 0 0", sel_drop, busy); end
    endtask

    task automatic test_reset_blank();
        sel = 3'd6; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rstblank_busy: got %b expected 1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if ({cur_sel, sel_ack, busy, out_valid} !== {3'd0, 3'b000}) begin n_errors++; $display("FAIL rstblank_state: cur_sel %0d ack %b busy %b valid %b expected 0 0 0 0", cur_sel, sel_ack, busy, out_valid); end
        for (int j = 0; j < 4; j++) begin
            step();
            n_checks++; if ({cur_sel, sel_ack, busy} !== {3'd0, 2'b00}) begin n_errors++; $display("FAIL rstblank_after %0d: cur_sel %0d ack %b busy %b expected 0 0 0", j, cur_sel, sel_ack, busy); end
        end
    endtask

    task automatic test_valid_tracking();
        logic [2:0] pattern;
        pattern = 3'b101;
        sel = 3'd2; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        for (int j = 0; j < 4; j++) step();
        n_checks++; if (cur_sel !== 3'd2) begin n_errors++; $display("FAIL valid_setup: cur_sel %0d expected 2", cur_sel); end
        for (int j = 2; j >= 0; j--) begin
            in_valid[2] = pattern[j];
            in_valid[0] = ~pattern[j];
            step();
            n_checks++; if (out_valid !== pattern[j]) begin n_errors++; $display("FAIL valid_track %0d: got %b expected %b", j, out_valid, pattern[j]); end
        end
        in_valid = 8'hFF;
    endtask

    task automatic test_out_of_range();
        step();
        sel6 = 3'd7; sel_req6 = 1'b1;
        step();
        sel_req6 = 1'b0;
`ifdef MUX_SEL_CHECK_EN
        n_checks++; if ({sel_drop6, sel_ack6, busy6, sel_err6, cur_sel6} !== {4'b1001, 3'd0}) begin n_errors++; $display("FAIL oor_reject: drop %b ack %b busy %b err %b cur_sel %0d expected 1 0 0 1 0", sel_drop6, sel_ack6, busy6, sel_err6, cur_sel6); end
        for (int j = 0; j < 4; j++) begin
            step();
            n_checks++; if ({sel_drop6, sel_ack6, sel_err6, cur_sel6, out_valid6} !== {3'b001, 3'd0, 1'b1}) begin n_errors++; $display("FAIL oor_sticky %0d: drop %b ack %b err %b cur_sel %0d valid %b expected 0 0 1 0 1", j, sel_drop6, sel_ack6, sel_err6, cur_sel6, out_valid6); end
        end
`else
        n_checks++; if ({busy6, out_valid6} !== 2'b10) begin n_errors++; $display("FAIL oor_blank: busy %b valid %b expected 1 0", busy6, out_valid6); end
        step(); step(); step();
        n_checks++; if ({sel_ack6, cur_sel6} !== {1'b1, 3'd7}) begin n_errors++; $display("FAIL oor_ack: ack %b cur_sel %0d expected 1 7", sel_ack6, cur_sel6); end
        for (int j = 0; j < 3; j++) begin
            step();
            n_checks++; if ({out_valid6, out_data6} !== 9'h000) begin n_errors++; $display("FAIL oor_data %0d: got %b/%h expected 0/00", j, out_valid6, out_data6); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_lane();
        test_busy_drop();
        test_back_to_back();
        test_reset_blank();
        test_valid_tracking();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
